mult_share_arbiter: RTL and testbench

- Shares one pipelined fixed-point multiplier among N_REQ requesters, for example the conv taps and the exp-series term generator.
- Uses a round-robin grant, with at most one issue per cycle.
- Tags each product with its requester and returns the truncated DATA_WIDTH result after a fixed latency of LPM_PIPE_WIDTH cycles.
- Sits between the cnn1d compute units and the single hard multiplier resource.

---
 rtl/cnn1d_pkg.sv | 32 +++
 rtl/fxp_mult_pipe.sv | 131 +++++++++++++
 rtl/mult_share_arbiter.sv | 115 +++++++++++
 tb/tb_mult_share_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cnn1d_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cnn1d_pkg
// Purpose  : Shared fixed-point constants, types and helper functions for the
//            cnn1d compute units and the shared multiplier arbiter.
// Contents : DATA_WIDTH, FRACTION, LPM_PIPE_WIDTH, LPM_OUT_WIDTH, LPM_OUT_MSB,
//            fxp_t (signed DATA_WIDTH word), clog2().
// Revision : 1.0 - initial release
// ============================================================================
package cnn1d_pkg;

  localparam int DATA_WIDTH     = 12;
  localparam int FRACTION       = 9;
  localparam int LPM_PIPE_WIDTH = 4;
  localparam int LPM_OUT_WIDTH  = 2 * DATA_WIDTH;
  // Top bit of the DATA_WIDTH window kept from the full-width product.
  localparam int LPM_OUT_MSB    = LPM_OUT_WIDTH - 1 - (DATA_WIDTH - FRACTION);

  typedef logic signed [DATA_WIDTH-1:0] fxp_t;

  // Ceiling log2, never less than 1 so it can size a pointer register.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fxp_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fxp_mult_pipe
// Purpose  : PIPE-deep signed DW x DW fixed-point multiplier carrying a valid
//            bit and a one-hot tag. The product window [DW+FRAC-1 -: DW] is
//            returned; ovf flags lost sign-extension bits.
// Macro    : CNN1D_MULT_SAT_EN - when defined, overflowing results saturate
//            to the most positive / most negative DW-bit value.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            in_valid/in_tag - issue strobe and one-hot requester tag
//            in_a, in_b      - signed operands
//            out_valid       - one-hot result strobe (tag of the result)
//            out_data        - result, holds when out_valid is 0
//            out_ovf         - truncation lost significant bits
//            busy            - any pipeline stage holds a valid operation
// Revision : 1.0 - initial release
// ============================================================================
module fxp_mult_pipe
  import cnn1d_pkg::*;
#(
  parameter int DW   = DATA_WIDTH,
  parameter int FRAC = FRACTION,
  parameter int PIPE = LPM_PIPE_WIDTH,
  parameter int TW   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [TW-1:0]        in_tag,
  input  logic signed [DW-1:0] in_a,
  input  logic signed [DW-1:0] in_b,
  output logic [TW-1:0]        out_valid,
  output logic [DW-1:0]        out_data,
  output logic                 out_ovf,
  output logic                 busy
);

  localparam int PW = 2 * DW;     // full product width
  localparam int KW = PW - FRAC;  // product bits above the discarded fraction

  logic signed [DW-1:0] a_q;
  logic signed [DW-1:0] b_q;
  logic [PIPE-1:0]      valid_q;
  logic [TW-1:0]        tag_q [PIPE];

  // Stage 0 captures operands; valid/tag shift down the pipe with the data.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      a_q <= in_a;
      b_q <= in_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < PIPE; k++) begin
        valid_q[k] <= 1'b0;
        tag_q[k]   <= '0;
      end
    end else begin
      valid_q[0] <= in_valid;
      tag_q[0]   <= in_tag;
      for (int k = 1; k < PIPE; k++) begin
        valid_q[k] <= valid_q[k-1];
        tag_q[k]   <= tag_q[k-1];
      end
    end
  end

  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] b_ext;
  logic signed [PW-1:0] prod_full;
  logic signed [KW-1:0] prod_0;
  logic signed [KW-1:0] prod_last;

  assign a_ext     = {{DW{a_q[DW-1]}}, a_q};
  assign b_ext     = {{DW{b_q[DW-1]}}, b_q};
  assign prod_full = a_ext * b_ext;
  // The fraction bits below the result window are never needed, so only the
  // upper KW bits are carried through the remaining stages.
  assign prod_0    = KW'(prod_full >>> FRAC);

  generate
    if (PIPE == 1) begin : g_no_delay
      assign prod_last = prod_0;
    end else begin : g_delay
      logic signed [KW-1:0] prod_q [1:PIPE-1];
      always_ff @(posedge clk) begin
        prod_q[1] <= prod_0;
        for (int k = 2; k < PIPE; k++) begin
          prod_q[k] <= prod_q[k-1];
        end
      end
      assign prod_last = prod_q[PIPE-1];
    end
  endgenerate

  // Bits from the product MSB down to the result MSB must all agree,
  // otherwise the DW-bit window cannot represent the value.
  logic [KW-DW:0] upper;
  logic           ovf_w;
  logic [DW-1:0]  data_w;

  assign upper = prod_last[KW-1:DW-1];
  assign ovf_w = !((&upper) || !(|upper));

  always_comb begin
    data_w = prod_last[DW-1:0];
`ifdef CNN1D_MULT_SAT_EN
    if (ovf_w) begin
      data_w = prod_last[KW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= '0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else begin
      out_valid <= valid_q[PIPE-1] ? tag_q[PIPE-1] : '0;
      out_ovf   <= valid_q[PIPE-1] & ovf_w;
      if (valid_q[PIPE-1]) out_data <= data_w;
    end
  end

  assign busy = |valid_q;

endmodule
`default_nettype wire

// File: rtl/mult_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mult_share_arbiter
// Purpose  : Round-robin sharing of one pipelined fixed-point multiplier among
//            N_REQ requesters. At most one issue per cycle; each result is
//            tagged one-hot with its requester and appears PIPE cycles later.
// Macro    : CNN1D_MULT_SAT_EN - saturate overflowing results (see
//            fxp_mult_pipe); latency and ovf are unchanged.
// Ports    : clk, rst   - clock, synchronous active-high reset
//            en         - grant enable (in-flight work still drains when low)
//            req_valid  - per-requester operand valid
//            req_a/b    - packed operands, requester i at [i*DW +: DW]
//            req_ready  - one-hot grant
//            res_valid  - one-hot result strobe
//            res_data   - shared result, qualified by res_valid
//            busy       - any operation in flight
//            ovf        - result truncation lost significant bits
// Revision : 1.0 - initial release
// ============================================================================
module mult_share_arbiter
  import cnn1d_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PIPE  = LPM_PIPE_WIDTH,
  parameter int DW    = DATA_WIDTH,
  parameter int FRAC  = FRACTION
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*DW-1:0] req_a,
  input  logic [N_REQ*DW-1:0] req_b,
  output logic [N_REQ-1:0]    req_ready,
  output logic [N_REQ-1:0]    res_valid,
  output logic [DW-1:0]       res_data,
  output logic                busy,
  output logic                ovf
);

  localparam int PTR_W = clog2(N_REQ);

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] cand_idx;
  logic [N_REQ-1:0] grant;
  logic             found;
  int               cand;

  // Search starts just after the last granted requester and wraps, so the
  // most recent winner has lowest priority on the next cycle.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand_idx  = '0;
    found     = 1'b0;
    cand      = 0;
    if (en && !rst) begin
      for (int off = 1; off <= N_REQ; off++) begin
        cand = int'(rr_ptr) + off;
        if (cand >= N_REQ) cand = cand - N_REQ;
        cand_idx = PTR_W'(cand);
        if (!found && req_valid[cand_idx]) begin
          found           = 1'b1;
          grant[cand_idx] = 1'b1;
          grant_idx       = cand_idx;
        end
      end
    end
  end

  assign req_ready = grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= PTR_W'(N_REQ - 1);
    end else if (found) begin
      rr_ptr <= grant_idx;
    end
  end

  logic signed [DW-1:0] a_sel;
  logic signed [DW-1:0] b_sel;

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        a_sel = req_a[i*DW +: DW];
        b_sel = req_b[i*DW +: DW];
      end
    end
  end

  fxp_mult_pipe #(
    .DW   (DW),
    .FRAC (FRAC),
    .PIPE (PIPE),
    .TW   (N_REQ)
  ) u_mult (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (found),
    .in_tag    (grant),
    .in_a      (a_sel),
    .in_b      (b_sel),
    .out_valid (res_valid),
    .out_data  (res_data),
    .out_ovf   (ovf),
    .busy      (busy)
  );

endmodule
`default_nettype wire

// File: tb/tb_mult_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_share_arbiter
// Purpose  : Directed self-checking bench for mult_share_arbiter (defaults:
//            N_REQ=4, PIPE=4, DW=12, FRAC=9). Honours CNN1D_MULT_SAT_EN for
//            the expected overflow results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_share_arbiter;

  localparam int N  = 4;
  localparam int DW = 12;

`ifdef CNN1D_MULT_SAT_EN
  localparam logic [DW-1:0] OVF_POS = 12'h7FF;
  localparam logic [DW-1:0] OVF_NEG = 12'h800;
`else
  localparam logic [DW-1:0] OVF_POS = 12'h200;
  localparam logic [DW-1:0] OVF_NEG = 12'hE00;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_a;
  logic [N*DW-1:0] req_b;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    res_valid;
  logic [DW-1:0]   res_data;
  logic            busy;
  logic            ovf;

  int n_cmp = 0;
  int n_bad = 0;

  mult_share_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
    .busy      (busy),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_a[idx*DW +: DW] = a;
    req_b[idx*DW +: DW] = b;
  endtask

  // One isolated request: grant, latency of 4 edges, result, ovf, drain.
  task automatic single(input string tag, input int idx, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [DW-1:0] exp_d,
                        input logic exp_o);
    set_req(idx, a, b);
    req_valid = 4'(1 << idx);
    #1;
    check({tag, "_ready"}, 32'(req_ready), 32'(1 << idx));
    tick;
    req_valid = '0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    repeat (3) tick;
    check({tag, "_early"}, 32'(res_valid), 32'd0);
    tick;
    check({tag, "_rvalid"}, 32'(res_valid), 32'(1 << idx));
    check({tag, "_data"}, 32'(res_data), 32'(exp_d));
    check({tag, "_ovf"}, 32'(ovf), 32'(exp_o));
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] bexp [N];

    // Reset, with requests pending and en high: reset must win.
    rst       = 1'b1;
    en        = 1'b1;
    req_valid = 4'b1111;
    req_a     = '0;
    req_b     = '0;
    tick;
    tick;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rvalid", 32'(res_valid), 32'd0);
    check("rst_data", 32'(res_data), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst       = 1'b0;
    req_valid = '0;
    tick;

    // 1.0 * 1.5 = 1.5
    single("one", 2, 12'h200, 12'h300, 12'h300, 1'b0);
    // -1 lsb * 1.0 stays -1 lsb (floor)
    single("neg1", 3, 12'hFFF, 12'h200, 12'hFFF, 1'b0);

    // Continuous demand from all four, pointer at 3: grants 0,1,2,3,0,1,2,3.
    for (int i = 0; i < N; i++) begin
      set_req(i, 12'h200, 12'((i + 1) * 12'h111));
      bexp[i] = 12'((i + 1) * 12'h111);
    end
    req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #1;
      check("burst_ready", 32'(req_ready), 32'(1 << (c % N)));
      tick;
      if (c >= 4) begin
        check("burst_rvalid", 32'(res_valid), 32'(1 << ((c - 4) % N)));
        check("burst_data", 32'(res_data), 32'(bexp[(c - 4) % N]));
      end
    end
    req_valid = '0;
    for (int c = 8; c < 12; c++) begin
      tick;
      check("burst_rvalid", 32'(res_valid), 32'(1 << ((c - 4) % N)));
      check("burst_data", 32'(res_data), 32'(bexp[(c - 4) % N]));
    end
    check("burst_idle", 32'(busy), 32'd0);

    // -1.0 * 0.5 = -0.5
    single("neg2", 2, 12'hE00, 12'h100, 12'hF00, 1'b0);
    tick;
    check("hold_rvalid", 32'(res_valid), 32'd0);
    check("hold_data", 32'(res_data), 32'hF00);
    // 3.0 * 3.0 and 3.0 * -3.0 overflow
    single("ovfp", 1, 12'h600, 12'h600, OVF_POS, 1'b1);
    single("ovfn", 0, 12'h600, 12'hA00, OVF_NEG, 1'b1);

    // en low blocks grants; pointer is 0 so req 1 wins before req 3.
    en = 1'b0;
    set_req(1, 12'h200, 12'h0AB);
    set_req(3, 12'h100, 12'h300);
    req_valid = 4'b1010;
    #1;
    check("en_low_ready", 32'(req_ready), 32'd0);
    tick;
    check("en_low_busy", 32'(busy), 32'd0);
    en = 1'b1;
    #1;
    check("en_first", 32'(req_ready), 32'b0010);
    tick;
    #1;
    check("en_second", 32'(req_ready), 32'b1000);
    tick;
    req_valid = '0;
    repeat (3) tick;
    check("en_res1_valid", 32'(res_valid), 32'b0010);
    check("en_res1_data", 32'(res_data), 32'h0AB);
    tick;
    check("en_res3_valid", 32'(res_valid), 32'b1000);
    check("en_res3_data", 32'(res_data), 32'h180);

    // Reset with three operations in flight (grants 0,1,2).
    set_req(0, 12'h200, 12'h155);
    req_valid = 4'b1111;
    #1;
    check("mid_g0", 32'(req_ready), 32'b0001);
    tick;
    #1;
    check("mid_g1", 32'(req_ready), 32'b0010);
    tick;
    #1;
    check("mid_g2", 32'(req_ready), 32'b0100);
    tick;
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    check("mid_busy", 32'(busy), 32'd1);
    tick;
    rst       = 1'b0;
    req_valid = '0;
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_data", 32'(res_data), 32'd0);
    for (int c = 0; c < 4; c++) begin
      check("post_rst_rvalid", 32'(res_valid), 32'd0);
      tick;
    end
    check("post_rst_rvalid", 32'(res_valid), 32'd0);
    req_valid = 4'b1111;
    #1;
    check("post_rst_grant", 32'(req_ready), 32'b0001);
    tick;
    req_valid = '0;
    repeat (4) tick;
    check("post_rst_res_valid", 32'(res_valid), 32'b0001);
    check("post_rst_res_data", 32'(res_data), 32'h155);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
